// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - Booth digit encodings and tree-sizing helpers for the multiply unit
package mul_pkg;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_digit_e;

    function automatic int booth_digits(input int width);
        return width / 2 + 1;
    endfunction

    // Radix-4 recoding of the bit triplet {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_e booth_decode(input logic [2:0] trip);
        booth_digit_e d;
        case (trip)
            3'b001, 3'b010: d = BOOTH_POS1;
            3'b011:         d = BOOTH_POS2;
            3'b100:         d = BOOTH_NEG2;
            3'b101, 3'b110: d = BOOTH_NEG1;
            default:        d = BOOTH_ZERO;
        endcase
        return d;
    endfunction

    function automatic int wallace_next(input int rows);
        return 2 * (rows / 3) + rows % 3;
    endfunction

    function automatic int wallace_levels(input int rows);
        int r;
        int n;
        r = rows;
        n = 0;
        while (r > 2) begin
            r = wallace_next(r);
            n++;
        end
        return n;
    endfunction

    function automatic int wallace_rows_at(input int rows, input int level);
        int r;
        r = rows;
        for (int l = 0; l < level; l++) r = wallace_next(r);
        return r;
    endfunction

endpackage

// File: rtl/booth_wallace_mul_pipe_if.sv
// rtl/booth_wallace_mul_pipe_if.sv - operand/result handshake bundle of the multiply unit
interface booth_wallace_mul_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/csa3to2.sv
// rtl/csa3to2.sv - 3:2 carry-save adder row; carry is pre-shifted into its weight
module csa3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);
    logic [W-2:0] w_maj;

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign w_maj   = (i_a[W-2:0] & i_b[W-2:0]) | (i_a[W-2:0] & i_c[W-2:0]) | (i_b[W-2:0] & i_c[W-2:0]);
    assign o_carry = {w_maj, 1'b0};
endmodule

// File: rtl/wallace_reduce.sv
// rtl/wallace_reduce.sv - combinational Wallace tree reducing ROWS addends to sum/carry
module wallace_reduce
    import mul_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0] i_rows,
    output logic [COLS-1:0]      o_sum,
    output logic [COLS-1:0]      o_carry
);
    localparam int LEVELS = wallace_levels(ROWS);

    genvar l, g, p;
    for (l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int R_IN  = wallace_rows_at(ROWS, l);
        localparam int R_OUT = wallace_rows_at(ROWS, l + 1);
        localparam int G     = R_IN / 3;

        logic [COLS-1:0] w_in  [0:R_IN-1];
        logic [COLS-1:0] w_out [0:R_OUT-1];

        for (p = 0; p < R_IN; p++) begin : g_src
            if (l == 0) begin : g_top
                assign w_in[p] = i_rows[p*COLS +: COLS];
            end else begin : g_prev
                assign w_in[p] = g_lvl[l-1].w_out[p];
            end
        end

        for (g = 0; g < G; g++) begin : g_csa
            csa3to2 #(.W(COLS)) u_csa (
                .i_a     (w_in[3*g]),
                .i_b     (w_in[3*g+1]),
                .i_c     (w_in[3*g+2]),
                .o_sum   (w_out[2*g]),
                .o_carry (w_out[2*g+1])
            );
        end

        // Leftover rows that do not fill a full triple ride to the next level untouched
        for (p = 0; p < R_IN % 3; p++) begin : g_pass
            assign w_out[2*G+p] = w_in[3*G+p];
        end
    end

    if (LEVELS == 0) begin : g_direct
        assign o_sum   = i_rows[0 +: COLS];
        assign o_carry = i_rows[COLS +: COLS];
    end else begin : g_tree
        assign o_sum   = g_lvl[LEVELS-1].w_out[0];
        assign o_carry = g_lvl[LEVELS-1].w_out[1];
    end
endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// rtl/booth_wallace_mul_pipe.sv - 3-stage radix-4 Booth / Wallace multiplier with valid/ready and tag
module booth_wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    booth_wallace_mul_pipe_if.slave   mul_if
);
    localparam int N    = booth_digits(WIDTH);
    localparam int P_W  = 2 * WIDTH;
    localparam int P_L  = WIDTH + 3;
    localparam int ROWS = N + 1;

    // Sum of the -2^(msb) terms that compensate the inverted sign bit of every partial product
    function automatic logic [P_W-1:0] sign_const();
        logic [P_W-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) k = k - (P_W'(1) << (P_L - 1 + 2 * i));
        return k;
    endfunction

    localparam logic [P_W-1:0] SIGN_K = sign_const();

    logic                 r_v1, r_v2, r_v3;
    logic [P_W-1:0]       r_pp [0:ROWS-1];
    logic [TAG_W-1:0]     r_tag1, r_tag2, r_tag3;
    logic [P_W-1:0]       r_sum, r_carry, r_prod;

    logic                 w_adv1, w_adv2, w_adv3, w_in_ready, w_accept;
    logic [P_L-1:0]       w_a_l, w_mag;
    logic [WIDTH+2:0]     w_b_pad;
    booth_digit_e         w_digit;
    logic [P_W-1:0]       w_pp [0:ROWS-1];
    logic [ROWS*P_W-1:0]  w_rows;
    logic [P_W-1:0]       w_sum, w_carry;

    assign w_adv3     = ~r_v3 | mul_if.out_ready;
    assign w_adv2     = ~r_v2 | w_adv3;
    assign w_adv1     = ~r_v1 | w_adv2;
    assign w_in_ready = flush | w_adv1;
    assign w_accept   = mul_if.in_valid & w_in_ready & ~flush;

    always_comb begin
        w_a_l   = {{3{mul_if.in_signed & mul_if.in_a[WIDTH-1]}}, mul_if.in_a};
        w_b_pad = {{2{mul_if.in_signed & mul_if.in_b[WIDTH-1]}}, mul_if.in_b, 1'b0};
        w_digit = BOOTH_ZERO;
        w_mag   = '0;
        for (int r = 0; r < ROWS; r++) w_pp[r] = '0;
        w_pp[N] = SIGN_K;
        for (int i = 0; i < N; i++) begin
            w_digit = booth_decode(w_b_pad[2*i +: 3]);
            case (w_digit)
                BOOTH_POS1: w_mag = w_a_l;
                BOOTH_POS2: w_mag = {w_a_l[P_L-2:0], 1'b0};
                BOOTH_NEG1: w_mag = ~w_a_l;
                BOOTH_NEG2: w_mag = ~{w_a_l[P_L-2:0], 1'b0};
                default:    w_mag = '0;
            endcase
            w_pp[i] = P_W'({~w_mag[P_L-1], w_mag[P_L-2:0]}) << (2 * i);
            // Negation +1 bits sit below the lowest set bit of SIGN_K, so they OR in cleanly
            if (w_digit == BOOTH_NEG1 || w_digit == BOOTH_NEG2) w_pp[N][2*i] = 1'b1;
        end
    end

    always_comb begin
        w_rows = '0;
        for (int r = 0; r < ROWS; r++) w_rows[r*P_W +: P_W] = r_pp[r];
    end

    wallace_reduce #(.ROWS(ROWS), .COLS(P_W)) u_tree (
        .i_rows  (w_rows),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            for (int r = 0; r < ROWS; r++) r_pp[r] <= '0;
            r_tag1  <= '0;
            r_tag2  <= '0;
            r_tag3  <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_prod  <= '0;
        end else begin
            if (flush) begin
                r_v1 <= 1'b0;
                r_v2 <= 1'b0;
                r_v3 <= 1'b0;
            end else begin
                if (w_adv1) r_v1 <= w_accept;
                if (w_adv2) r_v2 <= r_v1;
                if (w_adv3) r_v3 <= r_v2;
            end
            if (w_accept) begin
                for (int r = 0; r < ROWS; r++) r_pp[r] <= w_pp[r];
                r_tag1 <= mul_if.in_tag;
            end
            if (!flush && w_adv2 && r_v1) begin
                r_sum   <= w_sum;
                r_carry <= w_carry;
                r_tag2  <= r_tag1;
            end
            if (!flush && w_adv3 && r_v2) begin
                r_prod <= r_sum + r_carry;
                r_tag3 <= r_tag2;
            end
        end
    end

    assign mul_if.in_ready  = w_in_ready;
    assign mul_if.out_valid = r_v3;
    assign mul_if.out_prod  = r_prod;
    assign mul_if.out_tag   = r_tag3;
endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// tb/tb_booth_wallace_mul_pipe.sv - scoreboard bench for the pipelined Booth/Wallace multiplier
module tb_booth_wallace_mul_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    booth_wallace_mul_pipe_if #(.WIDTH(16), .TAG_W(4)) mul_if ();

    booth_wallace_mul_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .mul_if (mul_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        b2b_s [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] b2b_a [8] = '{16'h0003, 16'hFFFD, 16'h1234, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'h00FF};
    logic [15:0] b2b_b [8] = '{16'h0005, 16'h0005, 16'h0010, 16'h7FFF, 16'h7FFF, 16'h0002, 16'h8000, 16'h0101};
    logic [31:0] b2b_p [8] = '{32'h0000000F, 32'hFFFFFFF1, 32'h00012340, 32'h3FFF0001,
                               32'hC0008000, 32'h00010000, 32'h00000000, 32'h0000FFFF};

    logic        st_s [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] st_a [5] = '{16'h0002, 16'hFFFE, 16'h0100, 16'h0001, 16'hFFFF};
    logic [15:0] st_b [5] = '{16'h0003, 16'hFFFE, 16'h0100, 16'hFFFF, 16'h0001};
    logic [31:0] st_p [5] = '{32'h00000006, 32'h00000004, 32'h00010000, 32'hFFFFFFFF, 32'h0000FFFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        if (s) begin
            sa   = 32'(signed'(a));
            sb_v = 32'(signed'(b));
            return sa * sb_v;
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    task automatic send(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input logic [31:0] exp, input bit push, input bit lat);
        int budget;
        budget = 0;
        mul_if.in_valid  = 1'b1;
        mul_if.in_signed = s;
        mul_if.in_a      = a;
        mul_if.in_b      = b;
        mul_if.in_tag    = tag;
        #1;
        while (!mul_if.in_ready && budget < 100) begin
            @(negedge clk);
            mul_if.out_ready = 1'b1;
            #1;
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
        end else if (push) begin
            sb.push_back('{prod: exp, tag: tag, lat: lat, acc: cyc});
        end
        @(negedge clk);
        mul_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        mul_if.out_ready = 1'b1;
        while (sb.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && mul_if.out_valid && mul_if.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got prod 0x%0h tag %0d, required no output",
                             mul_if.out_prod, mul_if.out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("prod", mul_if.out_prod, e.prod);
                    check("tag", 32'(mul_if.out_tag), 32'(e.tag));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
                end
            end
        end
    end

    initial begin
        int acc;
        mul_if.in_valid  = 1'b0;
        mul_if.in_signed = 1'b0;
        mul_if.in_a      = '0;
        mul_if.in_b      = '0;
        mul_if.in_tag    = '0;
        mul_if.out_ready = 1'b1;
        #1 rst_n = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(mul_if.out_valid), 32'd0);
        check("rst_out_prod", mul_if.out_prod, 32'd0);
        check("rst_out_tag", 32'(mul_if.out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(mul_if.in_ready), 32'd1);
        @(negedge clk);

        send(1'b1, 16'h8000, 16'h8000, 4'h3, 32'h40000000, 1'b1, 1'b1);
        send(1'b0, 16'hFFFF, 16'hFFFF, 4'h1, 32'hFFFE0001, 1'b1, 1'b0);
        send(1'b1, 16'hFFFF, 16'h0002, 4'h2, 32'hFFFFFFFE, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) send(b2b_s[i], b2b_a[i], b2b_b[i], 4'(i), b2b_p[i], 1'b1, 1'b1);
        drain();

        acc = 0;
        mul_if.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mul_if.in_valid  = 1'b1;
            mul_if.in_signed = st_s[acc];
            mul_if.in_a      = st_a[acc];
            mul_if.in_b      = st_b[acc];
            mul_if.in_tag    = 4'(8 + acc);
            #1;
            if (mul_if.out_valid) check("stall_hold_prod", mul_if.out_prod, st_p[0]);
            if (mul_if.in_ready) begin
                sb.push_back('{prod: st_p[acc], tag: 4'(8 + acc), lat: 1'b0, acc: cyc});
                acc++;
            end
            @(negedge clk);
        end
        mul_if.in_valid = 1'b0;
        #1;
        check("stall_accepts", 32'(acc), 32'd3);
        check("stall_in_ready", 32'(mul_if.in_ready), 32'd0);
        check("stall_out_valid", 32'(mul_if.out_valid), 32'd1);
        check("stall_out_prod", mul_if.out_prod, st_p[0]);
        mul_if.out_ready = 1'b1;
        for (int k = acc; k < 5; k++) send(st_s[k], st_a[k], st_b[k], 4'(8 + k), st_p[k], 1'b1, 1'b0);
        drain();

        mul_if.out_ready = 1'b0;
        send(1'b0, 16'h0011, 16'h0011, 4'hD, 32'h00000121, 1'b0, 1'b0);
        send(1'b1, 16'h0003, 16'h0004, 4'hE, 32'h0000000C, 1'b0, 1'b0);
        send(1'b0, 16'h0005, 16'h0006, 4'hF, 32'h0000001E, 1'b0, 1'b0);
        #1;
        check("flush_pre_valid", 32'(mul_if.out_valid), 32'd1);
        flush            = 1'b1;
        mul_if.in_valid  = 1'b1;
        mul_if.in_signed = 1'b0;
        mul_if.in_a      = 16'h0007;
        mul_if.in_b      = 16'h0007;
        mul_if.in_tag    = 4'h9;
        #1;
        check("flush_in_ready", 32'(mul_if.in_ready), 32'd1);
        @(negedge clk);
        flush           = 1'b0;
        mul_if.in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(mul_if.out_valid), 32'd0);
        check("flush_hold_prod", mul_if.out_prod, 32'h00000121);
        mul_if.out_ready = 1'b1;
        send(1'b1, 16'hFFFF, 16'hFFFF, 4'h5, 32'h00000001, 1'b1, 1'b1);
        drain();

        mul_if.out_ready = 1'b0;
        send(1'b0, 16'h0009, 16'h0009, 4'h6, 32'h00000051, 1'b0, 1'b0);
        send(1'b1, 16'hFFF0, 16'h0010, 4'h7, 32'hFFFFFF00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_valid", 32'(mul_if.out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(mul_if.out_valid), 32'd0);
        check("async_rst_prod", mul_if.out_prod, 32'd0);
        check("async_rst_tag", 32'(mul_if.out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_valid", 32'(mul_if.out_valid), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 100; i++) begin
            logic        s;
            logic [15:0] a;
            logic [15:0] b;
            logic [3:0]  t;
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            t = 4'($urandom);
            mul_if.out_ready = ($urandom_range(0, 3) != 0);
            send(s, a, b, t, ref_mul(s, a, b), 1'b1, 1'b0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
